traffic_ctrl: RTL



---
 rtl/traffic_pkg.sv | 16 +
 rtl/tick_gen.sv | 28 ++
 rtl/traffic_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// State and light encodings shared by the traffic controller and the indicator/display blocks.
package traffic_pkg;

  typedef enum logic [2:0] {HG, HY, FG, FY, AR} state_e;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Timing-tick divider: one-cycle tick every TICK_DIV clocks, restarted by clr.
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic Clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int             DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (clr || tick) div_d = '0;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Highway/farm-road signal controller with ambulance all-red preemption (Moore outputs).
// Define FR_EXTEND_EN to hold farm green while a car is present, up to FR_MAX_GREEN ticks.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV     = 100000000,
  parameter int HW_MIN_GREEN = 10,
  parameter int YELLOW_TIME  = 3,
  parameter int FR_GREEN     = 5,
  parameter int FR_MAX_GREEN = 15
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       C,
  input  logic       AMB,
  output logic [1:0] HW_LIGHT,
  output logic [1:0] FR_LIGHT,
  output logic       AMB_ACTIVE
);

  localparam int TW_RAW = $clog2(max3(HW_MIN_GREEN, FR_MAX_GREEN, YELLOW_TIME) + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [TW-1:0] TCNT_MAX = '1;
  localparam logic [TW-1:0] HW_MIN_T = TW'(HW_MIN_GREEN);
  localparam logic [TW-1:0] YEL_T    = TW'(YELLOW_TIME);
  localparam logic [TW-1:0] FR_T     = TW'(FR_GREEN);

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_eff;
  logic          tick, state_chg, fg_done;

  assign state_chg = (state_d != state_q);

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .Clk   (Clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (tick)
  );

  // Count including this cycle's tick so every phase lasts an exact multiple of TICK_DIV.
  always_comb begin
    tcnt_eff = tcnt_q;
    if (tick && (tcnt_q != TCNT_MAX)) tcnt_eff = tcnt_q + 1'b1;
    tcnt_d = state_chg ? '0 : tcnt_eff;
  end

`ifdef FR_EXTEND_EN
  localparam logic [TW-1:0] FR_MAX_T = TW'(FR_MAX_GREEN);
  assign fg_done = (tcnt_eff >= FR_MAX_T) || (!C && (tcnt_eff >= FR_T));
`else
  assign fg_done = (tcnt_eff >= FR_T);
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= HG;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    HW_LIGHT   = LIGHT_RED;
    FR_LIGHT   = LIGHT_RED;
    AMB_ACTIVE = 1'b0;
    unique case (state_q)
      HG: begin
        HW_LIGHT = LIGHT_GREEN;
        if (AMB || (C && (tcnt_eff >= HW_MIN_T))) state_d = HY;
      end
      HY: begin
        HW_LIGHT = LIGHT_YELLOW;
        if (tcnt_eff >= YEL_T) state_d = AMB ? AR : FG;
      end
      FG: begin
        FR_LIGHT = LIGHT_GREEN;
        if (AMB || fg_done) state_d = FY;
      end
      FY: begin
        FR_LIGHT = LIGHT_YELLOW;
        if (tcnt_eff >= YEL_T) state_d = AMB ? AR : HG;
      end
      AR: begin
        AMB_ACTIVE = 1'b1;
        if (!AMB) state_d = HG;
      end
      default: state_d = HG;
    endcase
  end

endmodule
